crg_lane_unpacker: RTL and testbench
====================================

Name: crg_lane_unpacker

Overview:
- Consumer end of the SIMD-packed PRNG word format. The 256-bit word holds independent lanes: 8x32, 4x64, 2x128 or 1x256, selected by a width_t code.
- The block accepts one packed word with its width_t and mode_t tags over a valid/ready handshake.
- It emits the lanes one per cycle, lowest lane first, each zero-extended to 256 bits, over a second valid/ready handshake.
- It sits between the correlated-randomness generator output and lane-oriented consumers (share writers, host FIFO).

Parameters:
- W_DATA, `LEN_PRNG (256), packed word width; only 256 is supported.
- W_CNT, 32, width of the accepted-word counter.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  packed word valid.
- in_ready_o  output  1  block can accept a word this cycle.
- in_data_i  input  W_DATA  packed word (prng_t).
- in_width_i  input  3  lane width code (width_t).
- in_mode_i  input  3  mode tag (mode_t), passed through.
- out_valid_o  output  1  lane valid.
- out_ready_i  input  1  downstream accepts lane.
- out_data_o  output  W_DATA  current lane, zero-extended.
- out_idx_o  output  3  lane index within the word.
- out_last_o  output  1  current lane is the final lane of the word.
- out_width_o  output  3  width_t of the held word.
- out_mode_o  output  3  mode_t of the held word.
- word_cnt_o  output  W_CNT  number of words accepted since reset.

Behaviour:
- Width decode (priority order): is256 -> 256 bits, 1 lane; else is128 -> 128 bits, 2 lanes; else is64 -> 64 bits, 4 lanes; else 32 bits, 8 lanes. Non-canonical codes (e.g. 0b010) decode under this priority and are not errors.
- Lane k = held_data[k*W +: W]; lane 0 is the LSBs. Upper bits of out_data_o are 0.
- State machine:
  - IDLE: no word held.
  - EMIT: word held, idx counting.
- Reset values: state IDLE, out_valid_o 0, out_data_o 0, out_idx_o 0, out_last_o 0, out_width_o 0, out_mode_o 0, word_cnt_o 0. in_ready_o evaluates to 1.
- in_ready_o = (state==IDLE) | (out_valid_o & out_ready_i & out_last_o). This is combinational and allows back-to-back words with no bubble.
- Accept (in_valid_i & in_ready_o):
  - Register data, width and mode; idx <= 0; state -> EMIT; word_cnt_o += 1 (wraps modulo 2^W_CNT).
  - Lane 0 is visible in the next cycle.
  - Latency: accept in cycle N -> out_valid_o in cycle N+1.
- EMIT:
  - out_valid_o = 1.
  - On out_ready_i with !last: idx += 1.
  - On out_ready_i with last: if a new accept occurs in the same cycle, load it (idx 0, stay EMIT); otherwise go to IDLE with out_valid_o 0.
- Output stability: while out_valid_o & !out_ready_i, all out_* are held constant.
- Width, mode and data are sampled only at accept. in_* changes while in EMIT are ignored.
- out_last_o = (idx == lanes-1). For 256-bit words the first lane is also the last.
- Throughput: one lane per cycle with no backpressure; a 32-bit-mode word occupies 8 cycles.
- Reset mid-word: the held word is discarded and all outputs return to their reset values immediately (asynchronous). No partial lanes appear after release.
- The counter counts accepts, not lanes.

Decomposition:
- Add to FUNCS:
  - width_to_lanes(width_t) returning 4 bits (1/2/4/8).
  - width_to_bits(width_t) returning 9 bits, implementing the priority decode above.
- mode_t, width_t and prng_t already exist in TYPES and are reused.
- One combinational sub-module, crg_lane_mux: inputs held data, width and idx; output is the zero-extended lane. It is shared with future lane-oriented blocks.
- The unpacker holds the FSM, the registers and the counter.

Test Plan:
- Reset, then a single 256-bit word: in_width 0b111, data 0x..0123 -> one lane, out_idx 0, out_last 1, out_data equals the full word, word_cnt 1.
- 32-bit mode: data = {32'h7..,32'h6..,...,32'h0..}, width 0b000, out_ready tied 1 -> 8 consecutive lanes with values 0..7 in order, last asserted only on idx 7, in_ready high in the idx-7 cycle.
- Back-to-back: two 128-bit words, in_valid held high -> 4 lanes in 4 consecutive cycles with no bubble; out_mode follows the second word's tag from lane 0 of word 2.
- Backpressure: 64-bit word, out_ready toggled 1,0,0,1,1,1 -> out_* stable during stalls; lanes 0..3 each appear exactly once; in_ready stays low until last is consumed.
- Non-canonical width 0b010 -> decoded as 128-bit, 2 lanes.
- Width changes on in_width_i during EMIT do not alter the current word's lanes.
- Reset asserted mid-word at idx 2 of a 32-bit word -> out_valid 0 and word_cnt 0 immediately. After release, the next accepted word starts at idx 0 and no stale lanes appear.

Source files
------------

// File: rtl/crg_lane_unpacker_pkg.sv
// Shared types and width-decode helpers for the packed PRNG word format.
// A packed word holds 8x32, 4x64, 2x128 or 1x256 independent lanes.
package crg_lane_unpacker_pkg;

   localparam int LEN_PRNG = 256;

   typedef logic [LEN_PRNG-1:0] prng_t;

   // Canonical codes are 3'b000 (32), 3'b001 (64), 3'b011 (128) and 3'b111 (256).
   // Other codes decode by the priority is256 > is128 > is64.
   typedef struct packed {
      logic is256;
      logic is128;
      logic is64;
   } width_t;

   typedef enum logic [2:0] {
      MODE_RAW  = 3'd0,
      MODE_ADD  = 3'd1,
      MODE_XOR  = 3'd2,
      MODE_AND  = 3'd3,
      MODE_BIT  = 3'd4,
      MODE_RSV5 = 3'd5,
      MODE_RSV6 = 3'd6,
      MODE_RSV7 = 3'd7
   } mode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   function automatic logic [3:0] width_to_lanes(input width_t w);
      if (w.is256)      return 4'd1;
      else if (w.is128) return 4'd2;
      else if (w.is64)  return 4'd4;
      else              return 4'd8;
   endfunction

   function automatic logic [8:0] width_to_bits(input width_t w);
      if (w.is256)      return 9'd256;
      else if (w.is128) return 9'd128;
      else if (w.is64)  return 9'd64;
      else              return 9'd32;
   endfunction

endpackage

// File: rtl/crg_lane_unpacker_mux.sv
// Combinational lane selector: picks lane idx of a packed word and zero-extends it.
// Kept stand-alone so other lane-oriented blocks can reuse it.
module crg_lane_mux
   import crg_lane_unpacker_pkg::*;
(
   input  prng_t      data_i,
   input  width_t     width_i,
   input  logic [2:0] idx_i,
   output prng_t      lane_o
);

   logic [31:0]  lane32  [8];
   logic [63:0]  lane64  [4];
   logic [127:0] lane128 [2];

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_l32
         assign lane32[gi] = data_i[gi*32 +: 32];
      end
      for (genvar gi = 0; gi < 4; gi++) begin : g_l64
         assign lane64[gi] = data_i[gi*64 +: 64];
      end
      for (genvar gi = 0; gi < 2; gi++) begin : g_l128
         assign lane128[gi] = data_i[gi*128 +: 128];
      end
   endgenerate

   // Only the low idx bits that address a lane at this width are used.
   always_comb begin
      lane_o = '0;
      if (width_i.is256)      lane_o = data_i;
      else if (width_i.is128) lane_o[127:0] = lane128[idx_i[0]];
      else if (width_i.is64)  lane_o[63:0]  = lane64[idx_i[1:0]];
      else                    lane_o[31:0]  = lane32[idx_i];
   end

endmodule

// File: rtl/crg_lane_unpacker.sv
// Accepts one packed PRNG word and streams its lanes out lowest-first,
// one per cycle, each zero-extended to the full word width.
module crg_lane_unpacker
   import crg_lane_unpacker_pkg::*;
#(
   parameter int W_DATA = LEN_PRNG,
   parameter int W_CNT  = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [W_DATA-1:0] in_data_i,
   input  logic [2:0]        in_width_i,
   input  logic [2:0]        in_mode_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [W_DATA-1:0] out_data_o,
   output logic [2:0]        out_idx_o,
   output logic              out_last_o,
   output logic [2:0]        out_width_o,
   output logic [2:0]        out_mode_o,
   output logic [W_CNT-1:0]  word_cnt_o
);

   state_t             state_q;
   logic               valid_q;
   prng_t              data_q;
   width_t             width_q;
   mode_t              mode_q;
   logic [2:0]         idx_q;
   logic [W_CNT-1:0]   cnt_q;

   logic               last_c;
   logic               accept_c;
   prng_t              lane_c;

   // Last-lane flag is qualified by valid so it reads 0 while idle.
   assign last_c     = valid_q && ({1'b0, idx_q} == (width_to_lanes(width_q) - 4'd1));
   assign in_ready_o = (state_q == ST_IDLE) | (valid_q & out_ready_i & last_c);
   assign accept_c   = in_valid_i & in_ready_o;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         data_q  <= '0;
         width_q <= '0;
         mode_q  <= MODE_RAW;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         if (accept_c) begin
            state_q <= ST_EMIT;
            valid_q <= 1'b1;
            data_q  <= prng_t'(in_data_i);
            width_q <= width_t'(in_width_i);
            mode_q  <= mode_t'(in_mode_i);
            idx_q   <= '0;
            cnt_q   <= cnt_q + W_CNT'(1);
         end else if (state_q == ST_EMIT && out_ready_i) begin
            if (last_c) begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end else begin
               idx_q <= idx_q + 3'd1;
            end
         end
      end
   end

   crg_lane_mux u_lane_mux (
      .data_i  (data_q),
      .width_i (width_q),
      .idx_i   (idx_q),
      .lane_o  (lane_c)
   );

   assign out_valid_o = valid_q;
   assign out_data_o  = W_DATA'(lane_c);
   assign out_idx_o   = idx_q;
   assign out_last_o  = last_c;
   assign out_width_o = width_q;
   assign out_mode_o  = mode_q;
   assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_crg_lane_unpacker.sv
// Directed bench for crg_lane_unpacker with hand-built expected lanes.
module tb_crg_lane_unpacker;

   logic         clk_i = 1'b0;
   logic         rst_n_i = 1'b1;
   logic         in_valid_i = 1'b0;
   logic         in_ready_o;
   logic [255:0] in_data_i = '0;
   logic [2:0]   in_width_i = '0;
   logic [2:0]   in_mode_i = '0;
   logic         out_valid_o;
   logic         out_ready_i = 1'b0;
   logic [255:0] out_data_o;
   logic [2:0]   out_idx_o;
   logic         out_last_o;
   logic [2:0]   out_width_o;
   logic [2:0]   out_mode_o;
   logic [31:0]  word_cnt_o;

   int checks = 0;
   int errors = 0;

   crg_lane_unpacker #(.W_DATA(256), .W_CNT(32)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .in_width_i  (in_width_i),
      .in_mode_i   (in_mode_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_idx_o   (out_idx_o),
      .out_last_o  (out_last_o),
      .out_width_o (out_width_o),
      .out_mode_o  (out_mode_o),
      .word_cnt_o  (word_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (out_valid_o && out_ready_i)
         $display("lane idx=%0d last=%0d mode=%0d data=%0h", out_idx_o, out_last_o, out_mode_o, out_data_o);
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   logic [255:0] w256, w32, w64, wa, wb, w2;
   logic [255:0] lane_exp;
   logic [31:0]  l32;
   logic [63:0]  l64;
   int           bp_ready [6] = '{1, 0, 0, 1, 1, 1};
   int           bp_idx   [6] = '{0, 1, 1, 1, 2, 3};

   initial begin
      // Reset state
      #1 rst_n_i = 1'b0;
      #1;
      chk("rst_valid", out_valid_o, 0);
      chk("rst_data", out_data_o, 0);
      chk("rst_idx", out_idx_o, 0);
      chk("rst_last", out_last_o, 0);
      chk("rst_width", out_width_o, 0);
      chk("rst_mode", out_mode_o, 0);
      chk("rst_cnt", word_cnt_o, 0);
      chk("rst_ready", in_ready_o, 1);
      tick();
      tick();
      rst_n_i = 1'b1;
      tick();

      // Single 256-bit word
      w256 = {128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_0123};
      in_valid_i = 1'b1; in_width_i = 3'b111; in_mode_i = 3'd3; in_data_i = w256;
      tick();
      in_valid_i = 1'b0;
      #1;
      chk("w256_valid", out_valid_o, 1);
      chk("w256_idx", out_idx_o, 0);
      chk("w256_last", out_last_o, 1);
      chk("w256_data", out_data_o, w256);
      chk("w256_width", out_width_o, 3'b111);
      chk("w256_mode", out_mode_o, 3);
      chk("w256_cnt", word_cnt_o, 1);
      out_ready_i = 1'b1;
      tick();
      #1;
      chk("w256_done", out_valid_o, 0);

      // 32-bit mode, no backpressure
      for (int k = 0; k < 8; k++) w32[k*32 +: 32] = 32'hC0DE_0000 | 32'(k);
      in_valid_i = 1'b1; in_width_i = 3'b000; in_mode_i = 3'd0; in_data_i = w32;
      tick();
      in_valid_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         l32 = 32'hC0DE_0000 | 32'(k);
         chk("w32_valid", out_valid_o, 1);
         chk("w32_idx", out_idx_o, 256'(k));
         chk("w32_data", out_data_o, {224'b0, l32});
         chk("w32_last", out_last_o, (k == 7) ? 256'd1 : 256'd0);
         chk("w32_in_ready", in_ready_o, (k == 7) ? 256'd1 : 256'd0);
         tick();
      end
      #1;
      chk("w32_done", out_valid_o, 0);
      chk("w32_cnt", word_cnt_o, 2);

      // Back-to-back 128-bit words
      wa = {{4{32'h1A1A_1A1A}}, {4{32'h0A0A_0A0A}}};
      wb = {{4{32'h1B1B_1B1B}}, {4{32'h0B0B_0B0B}}};
      in_valid_i = 1'b1; in_width_i = 3'b011; in_mode_i = 3'd1; in_data_i = wa;
      tick();
      in_data_i = wb; in_mode_i = 3'd2;
      #1;
      chk("b2b_a0_data", out_data_o, {128'b0, {4{32'h0A0A_0A0A}}});
      chk("b2b_a0_mode", out_mode_o, 1);
      chk("b2b_a0_in_ready", in_ready_o, 0);
      tick();
      #1;
      chk("b2b_a1_data", out_data_o, {128'b0, {4{32'h1A1A_1A1A}}});
      chk("b2b_a1_last", out_last_o, 1);
      chk("b2b_a1_in_ready", in_ready_o, 1);
      tick();
      in_valid_i = 1'b0;
      #1;
      chk("b2b_b0_valid", out_valid_o, 1);
      chk("b2b_b0_idx", out_idx_o, 0);
      chk("b2b_b0_data", out_data_o, {128'b0, {4{32'h0B0B_0B0B}}});
      chk("b2b_b0_mode", out_mode_o, 2);
      chk("b2b_cnt", word_cnt_o, 4);
      tick();
      #1;
      chk("b2b_b1_data", out_data_o, {128'b0, {4{32'h1B1B_1B1B}}});
      chk("b2b_b1_last", out_last_o, 1);
      tick();
      #1;
      chk("b2b_done", out_valid_o, 0);

      // 64-bit word with backpressure; in_* scrambled during EMIT
      for (int k = 0; k < 4; k++) w64[k*64 +: 64] = 64'h6400_0000_0000_0000 | 64'(k);
      in_valid_i = 1'b1; in_width_i = 3'b001; in_mode_i = 3'd4; in_data_i = w64;
      tick();
      in_valid_i = 1'b0; in_width_i = 3'b111; in_mode_i = 3'd7; in_data_i = '1;
      for (int c = 0; c < 6; c++) begin
         out_ready_i = bp_ready[c][0];
         #1;
         l64 = 64'h6400_0000_0000_0000 | 64'(bp_idx[c]);
         chk("bp_valid", out_valid_o, 1);
         chk("bp_idx", out_idx_o, 256'(bp_idx[c]));
         chk("bp_data", out_data_o, {192'b0, l64});
         chk("bp_width", out_width_o, 3'b001);
         chk("bp_mode", out_mode_o, 4);
         chk("bp_in_ready", in_ready_o, (c == 5) ? 256'd1 : 256'd0);
         tick();
      end
      out_ready_i = 1'b1;
      #1;
      chk("bp_done", out_valid_o, 0);
      chk("bp_cnt", word_cnt_o, 5);

      // Non-canonical width 3'b010 behaves as 128-bit
      w2 = {128'h2222_2222_2222_2222_2222_2222_2222_2222, 128'h1111_1111_1111_1111_1111_1111_1111_1111};
      in_valid_i = 1'b1; in_width_i = 3'b010; in_mode_i = 3'd5; in_data_i = w2;
      tick();
      in_valid_i = 1'b0;
      #1;
      chk("nc_idx0", out_idx_o, 0);
      chk("nc_last0", out_last_o, 0);
      chk("nc_data0", out_data_o, {128'b0, 128'h1111_1111_1111_1111_1111_1111_1111_1111});
      chk("nc_width", out_width_o, 3'b010);
      tick();
      #1;
      chk("nc_idx1", out_idx_o, 1);
      chk("nc_last1", out_last_o, 1);
      chk("nc_data1", out_data_o, {128'b0, 128'h2222_2222_2222_2222_2222_2222_2222_2222});
      tick();
      #1;
      chk("nc_done", out_valid_o, 0);
      chk("nc_cnt", word_cnt_o, 6);

      // Reset in the middle of a 32-bit word
      in_valid_i = 1'b1; in_width_i = 3'b000; in_mode_i = 3'd2; in_data_i = w32;
      tick();
      in_valid_i = 1'b0;
      tick();
      tick();
      #1;
      chk("mid_idx2", out_idx_o, 2);
      chk("mid_data2", out_data_o, {224'b0, 32'hC0DE_0002});
      rst_n_i = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid_o, 0);
      chk("mid_rst_cnt", word_cnt_o, 0);
      chk("mid_rst_data", out_data_o, 0);
      chk("mid_rst_idx", out_idx_o, 0);
      chk("mid_rst_mode", out_mode_o, 0);
      tick();
      rst_n_i = 1'b1;
      tick();
      #1;
      chk("post_rst_valid", out_valid_o, 0);
      in_valid_i = 1'b1; in_width_i = 3'b111; in_mode_i = 3'd1; in_data_i = w256;
      tick();
      in_valid_i = 1'b0;
      #1;
      chk("post_rst_idx", out_idx_o, 0);
      chk("post_rst_data", out_data_o, w256);
      chk("post_rst_cnt", word_cnt_o, 1);
      chk("post_rst_last", out_last_o, 1);
      tick();
      #1;
      chk("post_rst_done", out_valid_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
